// File: rtl/mem_order_queue_if.sv
// Dispatch and issue handshake bundle for mem_order_queue.
// The master side is the dispatch/memory stage; the slave side is the queue itself.
interface mem_order_queue_if #(
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6
);
  // Dispatch channel
  logic              in_valid;
  logic              in_ready;
  logic [ROB_W-1:0]  in_rob_tag;
  logic              in_is_store;
  logic [PREG_W-1:0] in_addr_reg;
  logic [PREG_W-1:0] in_data_reg;

  // Issue channel
  logic              out_valid;
  logic              out_ready;
  logic [ROB_W-1:0]  out_rob_tag;
  logic              out_is_store;
  logic [PREG_W-1:0] out_addr_reg;
  logic [PREG_W-1:0] out_data_reg;

  modport master (
    output in_valid, in_rob_tag, in_is_store, in_addr_reg, in_data_reg, out_ready,
    input  in_ready, out_valid, out_rob_tag, out_is_store, out_addr_reg, out_data_reg
  );

  modport slave (
    input  in_valid, in_rob_tag, in_is_store, in_addr_reg, in_data_reg, out_ready,
    output in_ready, out_valid, out_rob_tag, out_is_store, out_addr_reg, out_data_reg
  );
endinterface

// File: rtl/mem_order_queue.sv
// Collapsing load/store ordering queue: index 0 is oldest, loads may bypass older loads,
// stores issue only from the head; supports ROB-tag flush and a valid/ready issue port.
module mem_order_queue #(
  parameter int DEPTH    = 8,
  parameter int ROB_W    = 5,
  parameter int PREG_W   = 6,
  parameter int NUM_PREG = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_order_queue_if.slave           bus,
  input  logic [NUM_PREG-1:0]        i_calc_list,
  input  logic [ROB_W-1:0]           i_rob_head,
  input  logic                       i_flush_valid,
  input  logic [ROB_W-1:0]           i_flush_rob_tag,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ROB_W-1:0]  rob_tag;
    logic              is_store;
    logic [PREG_W-1:0] addr_reg;
    logic [PREG_W-1:0] data_reg;
  } entry_t;

  entry_t           r_ent [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNT_W-1:0] r_count;

  entry_t           w_ent_nxt [DEPTH];
  logic [DEPTH-1:0] w_vld_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [DEPTH-1:0] w_elig;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  logic             w_issue;
  logic             w_alloc;
  logic [IDX_W-1:0] w_wr_idx;
  logic [ROB_W-1:0] w_flush_age;
  entry_t           w_in_ent;

  // Modular distance from the ROB head; the only way tags are ever ordered.
  function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] tag,
                                              input logic [ROB_W-1:0] head);
    return tag - head;
  endfunction

  // NOTE: every signal written in an always_comb gets a default before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin : eligibility
    logic store_older;
    logic rdy;
    store_older = 1'b0;
    rdy         = 1'b0;
    w_elig      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy = i_calc_list[r_ent[i].addr_reg] &
            (!r_ent[i].is_store | i_calc_list[r_ent[i].data_reg]);
      if (r_ent[i].is_store) begin
        // Index 0 means every older load and store has already left.
        w_elig[i] = r_vld[i] & rdy & (i == 0);
      end else begin
        w_elig[i] = r_vld[i] & rdy & !store_older;
      end
      if (r_vld[i] && r_ent[i].is_store) store_older = 1'b1;
    end
  end

  always_comb begin : select
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = IDX_W'(i);
    end
    w_found = |w_elig;
  end

  assign bus.out_valid    = w_found & !i_flush_valid;
  assign bus.out_rob_tag  = r_ent[w_sel].rob_tag;
  assign bus.out_is_store = r_ent[w_sel].is_store;
  assign bus.out_addr_reg = r_ent[w_sel].addr_reg;
  assign bus.out_data_reg = r_ent[w_sel].data_reg;

  assign bus.in_ready = (r_count < CNT_W'(DEPTH));
  assign w_issue      = bus.out_valid & bus.out_ready;
  assign w_alloc      = bus.in_valid & bus.in_ready & !i_flush_valid;
  assign w_wr_idx     = IDX_W'(r_count - CNT_W'(w_issue));
  assign w_flush_age  = age_of(i_flush_rob_tag, i_rob_head);

  assign w_in_ent.rob_tag  = bus.in_rob_tag;
  assign w_in_ent.is_store = bus.in_is_store;
  assign w_in_ent.addr_reg = bus.in_addr_reg;
  assign w_in_ent.data_reg = bus.in_data_reg;

  always_comb begin : next_state
    w_ent_nxt = r_ent;
    w_vld_nxt = r_vld;
    w_cnt_nxt = r_count;
    if (i_flush_valid) begin
      // Index order equals age order, so squashed entries always form the tail
      // and the survivors stay packed from index 0.
      for (int i = 0; i < DEPTH; i++) begin
        if (age_of(r_ent[i].rob_tag, i_rob_head) > w_flush_age) w_vld_nxt[i] = 1'b0;
      end
      w_cnt_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
        w_cnt_nxt = w_cnt_nxt + CNT_W'(w_vld_nxt[i]);
      end
    end else begin
      if (w_issue) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (IDX_W'(i) >= w_sel) begin
            w_ent_nxt[i] = r_ent[i+1];
            w_vld_nxt[i] = r_vld[i+1];
          end
        end
        w_vld_nxt[DEPTH-1] = 1'b0;
      end
      if (w_alloc) begin
        w_ent_nxt[w_wr_idx] = w_in_ent;
        w_vld_nxt[w_wr_idx] = 1'b1;
      end
      w_cnt_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_issue);
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_count <= '0;
    end else begin
      r_vld   <= w_vld_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  // NOTE: the payload array is deliberately not reset; r_vld alone defines which
  // entries are live, so clearing the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    r_ent <= w_ent_nxt;
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule
